// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared width, state type and Gray helper functions
package gray_pkg;

    localparam int GRAY_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;

    // Helpers work on a 32-bit zero-extended word; leading zeros decode to zeros.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] r;
        r[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            r[i] = r[i+1] ^ g[i];
        end
        return r;
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/gray_step_checker_graytobinary.sv
// rtl/gray_step_checker_graytobinary.sv - combinational W-bit Gray to binary decoder
module graytobinary
    import gray_pkg::*;
#(
    parameter int W = GRAY_W
) (
    input  logic [W-1:0] i_g,
    output logic [W-1:0] o_b
);

    logic [31:0] w_full;

    assign w_full = gray2bin(32'(i_g));
    assign o_b    = w_full[W-1:0];

endmodule

// File: rtl/gray_step_checker.sv
// rtl/gray_step_checker.sv - Gray stream sink: decode, single-bit step check, error count
module gray_step_checker
    import gray_pkg::*;
#(
    parameter int W     = GRAY_W,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             g_valid,
    input  logic [W-1:0]     g,
    input  logic             clear,
    output logic [W-1:0]     b,
    output logic             b_valid,
    output logic             dir,
    output logic             step_err,
    output logic [ERR_W-1:0] err_count,
    output logic             locked
);

    state_t           r_state, w_next_state;
    logic [W-1:0]     r_prev_g, r_prev_b, r_b;
    logic             r_b_valid, r_dir, r_step_err;
    logic [ERR_W-1:0] r_err_count;

    logic [W-1:0]     w_bin, w_inc;
    logic [5:0]       w_dist;
    logic [W-1:0]     w_prev_g_nxt, w_prev_b_nxt, w_b_nxt;
    logic             w_b_valid_nxt, w_dir_nxt, w_step_err_nxt;
    logic [ERR_W-1:0] w_err_count_nxt;

    graytobinary #(.W(W)) u_dec (
        .i_g (g),
        .o_b (w_bin)
    );

    assign w_dist = popcount(32'(g ^ r_prev_g));
    assign w_inc  = r_prev_b + W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_prev_g    <= '0;
            r_prev_b    <= '0;
            r_b         <= '0;
            r_b_valid   <= 1'b0;
            r_dir       <= 1'b0;
            r_step_err  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_next_state;
            r_prev_g    <= w_prev_g_nxt;
            r_prev_b    <= w_prev_b_nxt;
            r_b         <= w_b_nxt;
            r_b_valid   <= w_b_valid_nxt;
            r_dir       <= w_dir_nxt;
            r_step_err  <= w_step_err_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_prev_g_nxt    = r_prev_g;
        w_prev_b_nxt    = r_prev_b;
        w_b_nxt         = r_b;
        w_b_valid_nxt   = 1'b0;
        w_dir_nxt       = r_dir;
        w_step_err_nxt  = 1'b0;
        w_err_count_nxt = r_err_count;

        if (clear) begin
            w_next_state    = IDLE;
            w_b_nxt         = '0;
            w_dir_nxt       = 1'b0;
            w_err_count_nxt = '0;
        end else if (g_valid) begin
            w_b_nxt       = w_bin;
            w_b_valid_nxt = 1'b1;
            case (r_state)
                TRACK: begin
                    if (w_dist == 6'd1) begin
                        w_dir_nxt    = (w_bin == w_inc);
                        w_prev_g_nxt = g;
                        w_prev_b_nxt = w_bin;
                    end else if (w_dist != 6'd0) begin
                        w_step_err_nxt = 1'b1;
                        w_next_state   = ERROR;
                        if (r_err_count != {ERR_W{1'b1}}) begin
                            w_err_count_nxt = r_err_count + ERR_W'(1);
                        end
                    end
                end
                // IDLE and ERROR both take the sample as an unchecked seed.
                default: begin
                    w_prev_g_nxt = g;
                    w_prev_b_nxt = w_bin;
                    w_next_state = TRACK;
                end
            endcase
        end
    end

    assign b         = r_b;
    assign b_valid   = r_b_valid;
    assign dir       = r_dir;
    assign step_err  = r_step_err;
    assign err_count = r_err_count;
    assign locked    = (r_state == TRACK);

endmodule
